// File: rtl/mips_run_controller.sv
// Program memory and run control for a single-cycle MIPS core: byte loading in IDLE,
// release on start, halt-on-nop with drain, cycle/retire counts. Watchdog under RUN_TIMEOUT_EN.
module mips_run_controller #(
  parameter int ADDR_W       = 8,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16,
  parameter int TIMEOUT      = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              load_err,
  input  logic              start,
  input  logic              clear,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       instr,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retired_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DRN_W-1:0]   drn_q, drn_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]   retired_cnt_q, retired_cnt_d;
  logic               load_err_q, load_err_d;
  logic               timeout_q, timeout_d;
  logic               core_reset_q, core_reset_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mem_we;
  logic               wd_hit;
  logic [7:0]         mem_q [DEPTH];
  logic [ADDR_W-3:0]  widx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Word-aligned little-endian fetch; the low two PC bits never select a byte lane.
  assign widx  = fetch_addr[ADDR_W-1:2];
  assign instr = {mem_q[{widx, 2'd3}], mem_q[{widx, 2'd2}],
                  mem_q[{widx, 2'd1}], mem_q[{widx, 2'd0}]};

`ifdef RUN_TIMEOUT_EN
  assign wd_hit = (cycle_cnt_q >= CNT_W'(TIMEOUT));
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = TIMEOUT;
  assign wd_hit         = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    drn_d         = drn_q;
    cycle_cnt_d   = cycle_cnt_q;
    retired_cnt_d = retired_cnt_q;
    timeout_d     = timeout_q;
    mem_we        = 1'b0;
    load_err_d    = 1'b0;

    if (load_en) begin
      if (state_q == S_IDLE) mem_we = 1'b1;
      else                   load_err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_RUN;
          cycle_cnt_d   = '0;
          retired_cnt_d = '0;
          timeout_d     = 1'b0;
        end
      end
      S_RUN: begin
        if (wd_hit) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          cycle_cnt_d = sat_inc(cycle_cnt_q);
          if (instr != 32'd0) begin
            retired_cnt_d = sat_inc(retired_cnt_q);
          end else if (DRAIN_CYCLES > 0) begin
            state_d = S_DRAIN;
            drn_d   = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DRAIN: begin
        if (wd_hit) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          cycle_cnt_d = sat_inc(cycle_cnt_q);
          if (drn_q == DRN_LAST) state_d = S_DONE;
          else                   drn_d   = drn_q + 1'b1;
        end
      end
      S_DONE: begin
        if (clear) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    core_reset_d = !((state_d == S_RUN) || (state_d == S_DRAIN));
    busy_d       = !core_reset_d;
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      drn_q         <= '0;
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
      load_err_q    <= 1'b0;
      timeout_q     <= 1'b0;
      core_reset_q  <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      drn_q         <= drn_d;
      cycle_cnt_q   <= cycle_cnt_d;
      retired_cnt_q <= retired_cnt_d;
      load_err_q    <= load_err_d;
      timeout_q     <= timeout_d;
      core_reset_q  <= core_reset_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (mem_we) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign load_err    = load_err_q;
  assign timeout     = timeout_q;
  assign core_reset  = core_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign retired_cnt = retired_cnt_q;

endmodule

// File: doc/mips_run_controller.md
Name: mips_run_controller

Overview:
- Parametrised program-memory and run-control block wrapped around the single-cycle MIPS core.
- Holds a byte-addressed, little-endian instruction memory, loaded byte by byte while the core is held in reset. Serves 32-bit instruction fetches.
- Releases the core on start. Detects the halt (all-zero/nop) instruction, lets the core drain a programmable number of cycles, then re-holds it and reports cycle and retired-instruction counts.

Parameters:
- ADDR_W, 8, byte-address width; memory depth = 2**ADDR_W bytes
- DRAIN_CYCLES, 3, cycles the core keeps running after halt fetch (0 allowed)
- CNT_W, 16, width of cycle/retired counters
- TIMEOUT, 1024, RUN+DRAIN cycle limit (used only with RUN_TIMEOUT_EN)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- load_en  input  1  byte write strobe
- load_addr  input  ADDR_W  byte address for load
- load_data  input  8  byte to write
- load_err  output  1  one-cycle pulse: load_en asserted outside IDLE
- start  input  1  begin execution (honoured in IDLE only)
- clear  input  1  return DONE -> IDLE (honoured in DONE only)
- fetch_addr  input  ADDR_W  core PC (byte address)
- instr  output  32  fetched instruction
- core_reset  output  1  reset to core; high except in RUN/DRAIN
- busy  output  1  high in RUN or DRAIN
- done  output  1  high in DONE
- timeout  output  1  DONE reached via watchdog
- cycle_cnt  output  CNT_W  cycles spent in RUN+DRAIN
- retired_cnt  output  CNT_W  nonzero instructions fetched in RUN

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all 2**ADDR_W memory bytes=0; cycle_cnt=0, retired_cnt=0, load_err=0, timeout=0; core_reset=1, busy=0, done=0. Reset mid-run aborts immediately; core_reset stays high throughout.
- Fetch is combinational. With a = {fetch_addr[ADDR_W-1:2],2'b00}: instr = {mem[a+3],mem[a+2],mem[a+1],mem[a]}.
  - Low two address bits are ignored.
  - Fetch is valid in every state.
- Load: in IDLE, load_en writes load_data to mem[load_addr] at the clock edge; a fetch of the same word shows new data the next cycle. Outside IDLE, the write is dropped and load_err pulses high for the next cycle.
- States and transitions:
  - IDLE: start=1 -> RUN; cycle_cnt and retired_cnt cleared to 0 on that edge. Load and start in the same cycle: the byte is written and RUN entered.
  - RUN: every cycle cycle_cnt+1.
    - instr != 0: retired_cnt+1.
    - instr == 0: DRAIN if DRAIN_CYCLES>0, else DONE.
  - DRAIN: exactly DRAIN_CYCLES cycles, cycle_cnt+1 each, retired_cnt frozen; then DONE. Zero instructions during DRAIN are ignored.
  - DONE: counters frozen, core_reset=1, done=1; clear=1 -> IDLE (memory and counters preserved until next start). start ignored in DONE and RUN/DRAIN.
- Counters saturate at 2**CNT_W-1 (no wrap).
- Fetch addresses wrap modulo 2**ADDR_W; word at top of memory uses bytes 2**ADDR_W-4..2**ADDR_W-1.
- All outputs except instr are registered.

Optional Feature:
- Macro RUN_TIMEOUT_EN.
- Defined: watchdog active. In RUN or DRAIN, if cycle_cnt reaches TIMEOUT, the next edge enters DONE with timeout=1, overriding halt/drain progress. timeout is cleared on entry to RUN and on reset.
- Undefined: no watchdog logic; timeout tied 0; TIMEOUT unused.

Test Plan:
- Load words 0x200a000a, 0x016a5820, 0x200a000d, 0x014b6022, 0xad4c0000, 0x8d4d0000 little-endian at bytes 0..23; start; bench model drives fetch_addr=4*RUN/DRAIN cycle index -> instr matches each word in order, halt at byte 24, retired_cnt=6, cycle_cnt=10 (7 RUN + 3 DRAIN), done=1, core_reset=1.
- Same program with DRAIN_CYCLES=0 -> DONE the cycle after the nop fetch, cycle_cnt=7, retired_cnt=6.
- load_en during RUN at load_addr=0 with load_data=0xff -> load_err pulses 1 cycle; after clear, fetch_addr=0 returns 0x200a000a unchanged.
- fetch_addr=0x03 and 0x01 -> same instr as 0x00; fetch_addr=0xfc -> bytes 0xfc..0xff.
- Assert reset during DRAIN -> next cycle state IDLE, counters 0, all memory 0, core_reset=1.
- RUN_TIMEOUT_EN, TIMEOUT=20, program with no zero word in reach (fetch_addr held at 0) -> DONE with timeout=1, cycle_cnt=20; without the macro the bench sees busy held high beyond 20 cycles.
